complex_axpy_sequencer: RTL and testbench

- Job controller for the NI-lane complex multiply/add datapath, which computes z = y ± c·x on NI 64-bit complex elements per cycle.
- On `start`, the block streams ceil(NOE/NI) chunk reads from the x and y vector memories and drives the datapath op.
- It tracks the fixed memory-plus-pipeline latency with a valid shift register, issues write-backs of results to the z memory with a per-lane mask, and pulses `done`.

---
 rtl/complex_axpy_sequencer.sv | 171 +++++++++++++++++
 tb/tb_complex_axpy_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/complex_axpy_sequencer.sv
// Job sequencer for the NI-lane complex z = y +/- c*x datapath: streams chunk reads,
// tracks memory+pipeline latency with a valid shift register and issues masked write-backs.
module complex_axpy_sequencer #(
  parameter int unsigned NOE      = 19,
  parameter int unsigned NI       = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned PIPE_LAT = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op_in,
  input  logic [ADDR_W-1:0] x_base,
  input  logic [ADDR_W-1:0] y_base,
  input  logic [ADDR_W-1:0] z_base,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] x_addr,
  output logic [ADDR_W-1:0] y_addr,
  output logic              dp_op,
  output logic              wr_en,
  output logic [ADDR_W-1:0] z_addr,
  output logic [NI-1:0]     wr_mask
);

  localparam int unsigned CHUNKS = (NOE + NI - 1) / NI;
  localparam int unsigned REM    = NOE % NI;
  localparam int unsigned LAT    = MEM_LAT + PIPE_LAT;
  localparam int unsigned CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  // wr_en_q itself is the final stage of the LAT-deep valid pipeline
  localparam int unsigned SRW    = LAT - 1;

  localparam logic [NI-1:0] FULL_MASK = '1;
  localparam logic [NI-1:0] LAST_MASK = (REM == 0) ? FULL_MASK
                                                   : ((NI'(1) << REM) - NI'(1));
  localparam logic [CW-1:0] LAST_IDX  = CW'(CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] x_addr_q, x_addr_d;
  logic [ADDR_W-1:0] y_addr_q, y_addr_d;
  logic              dp_op_q, dp_op_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] z_addr_q, z_addr_d;
  logic [NI-1:0]     wr_mask_q, wr_mask_d;
  logic [ADDR_W-1:0] z_base_q, z_base_d;
  logic [CW-1:0]     k_q, k_d;
  logic [CW-1:0]     w_q, w_d;
  logic              wr_last_q, wr_last_d;
  logic [SRW-1:0]    sr_q, sr_d;

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_en_d   = 1'b0;
    x_addr_d  = x_addr_q;
    y_addr_d  = y_addr_q;
    dp_op_d   = dp_op_q;
    z_base_d  = z_base_q;
    k_d       = k_q;
    z_addr_d  = z_addr_q;
    wr_mask_d = '0;
    w_d       = w_q;
    wr_last_d = 1'b0;

    // Valid pipeline: a read issued now becomes a write LAT cycles later
    sr_d    = (sr_q << 1) | SRW'(rd_en_q);
    wr_en_d = sr_q[SRW-1];

    if (wr_en_d) begin
      z_addr_d  = z_base_q + ADDR_W'(w_q);
      wr_last_d = (w_q == LAST_IDX);
      wr_mask_d = wr_last_d ? LAST_MASK : FULL_MASK;
      w_d       = wr_last_d ? '0 : w_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ISSUE;
          busy_d   = 1'b1;
          rd_en_d  = 1'b1;
          x_addr_d = x_base;
          y_addr_d = y_base;
          z_base_d = z_base;
          dp_op_d  = op_in;
          k_d      = '0;
        end
      end
      ISSUE: begin
        // k_q is the index of the read currently on the bus
        if (k_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          rd_en_d  = 1'b1;
          x_addr_d = x_addr_q + ADDR_W'(1);
          y_addr_d = y_addr_q + ADDR_W'(1);
          k_d      = k_q + CW'(1);
        end
      end
      DRAIN: begin
        if (wr_en_q && wr_last_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      x_addr_q  <= '0;
      y_addr_q  <= '0;
      dp_op_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      z_addr_q  <= '0;
      wr_mask_q <= '0;
      z_base_q  <= '0;
      k_q       <= '0;
      w_q       <= '0;
      wr_last_q <= 1'b0;
      sr_q      <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      x_addr_q  <= x_addr_d;
      y_addr_q  <= y_addr_d;
      dp_op_q   <= dp_op_d;
      wr_en_q   <= wr_en_d;
      z_addr_q  <= z_addr_d;
      wr_mask_q <= wr_mask_d;
      z_base_q  <= z_base_d;
      k_q       <= k_d;
      w_q       <= w_d;
      wr_last_q <= wr_last_d;
      sr_q      <= sr_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_en   = rd_en_q;
  assign x_addr  = x_addr_q;
  assign y_addr  = y_addr_q;
  assign dp_op   = dp_op_q;
  assign wr_en   = wr_en_q;
  assign z_addr  = z_addr_q;
  assign wr_mask = wr_mask_q;

endmodule

// File: tb/tb_complex_axpy_sequencer.sv
// Scoreboard bench for complex_axpy_sequencer: NOE=19 main instance plus an NOE=16 instance.
module tb_complex_axpy_sequencer;

  localparam int LAT    = 10;
  localparam int CHUNKS = 3;

  typedef struct {
    int         cyc;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] mask;
    logic       op;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset, start, start16, op_in;
  logic [7:0] x_base, y_base, z_base;

  logic       busy, done, rd_en, dp_op, wr_en;
  logic [7:0] x_addr, y_addr, z_addr, wr_mask;
  logic       busy_b, done_b, rd_en_b, dp_op_b, wr_en_b;
  logic [7:0] x_addr_b, y_addr_b, z_addr_b, wr_mask_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic mon_en = 1'b0;

  ev_t rd_q[$];
  ev_t wr_q[$];
  int  done_q[$];
  int  busy_lo    = -1;
  int  busy_hi    = -2;
  int  model_free = 0;
  ev_t mon_e;
  int  mon_d;

  int exp_done16 = -1;
  int wr16_cnt   = 0;
  int done16_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  complex_axpy_sequencer u_dut (
    .clk(clk), .reset(reset), .start(start), .op_in(op_in),
    .x_base(x_base), .y_base(y_base), .z_base(z_base),
    .busy(busy), .done(done), .rd_en(rd_en), .x_addr(x_addr), .y_addr(y_addr),
    .dp_op(dp_op), .wr_en(wr_en), .z_addr(z_addr), .wr_mask(wr_mask)
  );

  complex_axpy_sequencer #(.NOE(16)) u_dut16 (
    .clk(clk), .reset(reset), .start(start16), .op_in(op_in),
    .x_base(x_base), .y_base(y_base), .z_base(z_base),
    .busy(busy_b), .done(done_b), .rd_en(rd_en_b), .x_addr(x_addr_b), .y_addr(y_addr_b),
    .dp_op(dp_op_b), .wr_en(wr_en_b), .z_addr(z_addr_b), .wr_mask(wr_mask_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs; the model predicts the job if the DUT is idle now
  task automatic step(input logic s, input logic o, input logic [7:0] xb,
                      input logic [7:0] yb, input logic [7:0] zb, input logic r);
    ev_t e;
    int  t;
    reset  = r;
    start  = s;
    op_in  = o;
    x_base = xb;
    y_base = yb;
    z_base = zb;
    t = cyc;
    if (!r && s && t >= model_free) begin
      for (int k = 0; k < CHUNKS; k++) begin
        e.cyc = t + 1 + k; e.a = xb + 8'(k); e.b = yb + 8'(k); e.mask = 8'h00; e.op = o;
        rd_q.push_back(e);
        e.cyc = t + 1 + LAT + k; e.a = zb + 8'(k); e.b = 8'h00;
        e.mask = (k == CHUNKS - 1) ? 8'h07 : 8'hFF;
        wr_q.push_back(e);
      end
      done_q.push_back(t + CHUNKS + LAT + 1);
      busy_lo    = t + 1;
      busy_hi    = t + CHUNKS + LAT + 1;
      model_free = t + CHUNKS + LAT + 2;
    end
    @(posedge clk);
    #1;
    if (r) begin
      rd_q.delete();
      wr_q.delete();
      done_q.delete();
      busy_lo    = -1;
      busy_hi    = -2;
      model_free = cyc;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_en) begin
        if (rd_q.size() == 0) check_eq("rd_unexpected", 32'(rd_en), 32'd0);
        else begin
          mon_e = rd_q.pop_front();
          check_eq("rd_cycle", 32'(cyc), 32'(mon_e.cyc));
          check_eq("x_addr", 32'(x_addr), 32'(mon_e.a));
          check_eq("y_addr", 32'(y_addr), 32'(mon_e.b));
          check_eq("dp_op_rd", 32'(dp_op), 32'(mon_e.op));
        end
      end
      if (wr_en) begin
        if (wr_q.size() == 0) check_eq("wr_unexpected", 32'(wr_en), 32'd0);
        else begin
          mon_e = wr_q.pop_front();
          check_eq("wr_cycle", 32'(cyc), 32'(mon_e.cyc));
          check_eq("z_addr", 32'(z_addr), 32'(mon_e.a));
          check_eq("wr_mask", 32'(wr_mask), 32'(mon_e.mask));
          check_eq("dp_op_wr", 32'(dp_op), 32'(mon_e.op));
        end
      end else begin
        check_eq("wr_mask_idle", 32'(wr_mask), 32'd0);
      end
      if (done) begin
        if (done_q.size() == 0) check_eq("done_unexpected", 32'(done), 32'd0);
        else begin
          mon_d = done_q.pop_front();
          check_eq("done_cycle", 32'(cyc), 32'(mon_d));
        end
      end
      check_eq("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));

      if (wr_en_b) begin
        wr16_cnt++;
        check_eq("n16_wr_mask", 32'(wr_mask_b), 32'hFF);
        check_eq("n16_dp_op", 32'(dp_op_b), 32'd1);
      end
      if (done_b) begin
        done16_cnt++;
        check_eq("n16_done_cycle", 32'(cyc), 32'(exp_done16));
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; start16 = 1'b0; op_in = 1'b0;
    x_base = 8'h00; y_base = 8'h00; z_base = 8'h00;
    step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    check_eq("rst_ctrl", 32'({busy, done, rd_en, wr_en, dp_op}), 32'd0);
    check_eq("rst_addr", {x_addr, y_addr, z_addr, wr_mask}, 32'd0);
    step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    mon_en = 1'b1;

    // Basic add job
    step(1'b1, 1'b0, 8'h10, 8'h20, 8'h30, 1'b0);
    idle(16);

    // NOE=16 subtract job on the second instance
    start16 = 1'b1;
    exp_done16 = cyc + 13;
    step(1'b0, 1'b1, 8'h40, 8'h50, 8'h60, 1'b0);
    start16 = 1'b0;
    idle(16);
    check_eq("n16_wr_count", 32'(wr16_cnt), 32'd2);
    check_eq("n16_done_count", 32'(done16_cnt), 32'd1);

    // Start while busy must be ignored, op unchanged
    step(1'b1, 1'b0, 8'h01, 8'h02, 8'h03, 1'b0);
    idle(4);
    step(1'b1, 1'b1, 8'hA0, 8'hB0, 8'hC0, 1'b0);
    idle(14);

    // Address wrap
    step(1'b1, 1'b1, 8'hFE, 8'h7F, 8'hFF, 1'b0);
    idle(16);

    // Reset mid-job, then a fresh job
    step(1'b1, 1'b0, 8'h11, 8'h22, 8'h33, 1'b0);
    idle(7);
    step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    check_eq("midrst_ctrl", 32'({busy, done, rd_en, wr_en, dp_op}), 32'd0);
    check_eq("midrst_addr", {x_addr, y_addr, z_addr, wr_mask}, 32'd0);
    idle(15);
    step(1'b1, 1'b1, 8'h05, 8'h06, 8'h07, 1'b0);
    idle(16);

    // Start held high: back-to-back jobs
    for (int i = 0; i < 48; i++)
      step(1'b1, 1'(i % 2), 8'(i * 3), 8'(i * 5 + 1), 8'(i * 7 + 2), 1'b0);
    idle(1);

    for (int i = 0; i < 40 && (rd_q.size() + wr_q.size() + done_q.size()) != 0; i++)
      idle(1);
    check_eq("rd_left", 32'(rd_q.size()), 32'd0);
    check_eq("wr_left", 32'(wr_q.size()), 32'd0);
    check_eq("done_left", 32'(done_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
